// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned imem requests, buffers {instruction, pc} in a small FIFO, handles redirects.
// Define FETCH_PREFETCH_EN for a 2-entry buffer (one request in flight while one entry is held); default is 1 entry.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 32
`endif

module fetch_unit #(
    parameter logic [`MEM_ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req_o,
    output logic [`MEM_ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                       imem_ack_i,
    input  logic [`MEM_DATA_WIDTH-1:0] imem_data_i,
    input  logic                       redirect_i,
    input  logic [`MEM_ADDR_WIDTH-1:0] redirect_pc_i,
    input  logic                       stall_i,
    output logic                       instr_valid_o,
    output logic [`MEM_DATA_WIDTH-1:0] instruction_o,
    output logic [`MEM_ADDR_WIDTH-1:0] pc_o
);

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int AW    = `MEM_ADDR_WIDTH;
    localparam int DW    = `MEM_DATA_WIDTH;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] NOP = DW'(32'h0000_0013);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        FLUSH
    } state_t;

    typedef struct packed {
        logic [DW-1:0] instr;
        logic [AW-1:0] pc;
    } entry_t;

    state_t           state;
    logic [AW-1:0]    fetch_pc;
    logic [AW-1:0]    req_addr;
    entry_t           buf_mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count_after;
    logic [AW-1:0]    next_pc;
    logic [AW-1:0]    redirect_target;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign redirect_target = redirect_pc_i & ~AW'(3);
    assign next_pc         = req_addr + AW'(4);

    assign instr_valid_o = (count != '0);
    // Redirect wins over both buffer operations: the flush discards everything.
    assign pop         = instr_valid_o && !stall_i && !redirect_i;
    assign push        = (state == FETCH) && imem_ack_i && !redirect_i;
    assign count_after = count + CNT_W'(push) - CNT_W'(pop);

    // NOTE: the request is gated by rst directly so it drops the instant reset asserts
    // and rises in the very first cycle after release, without waiting for an edge.
    assign imem_req_o  = !rst && (state != HOLD);
    assign imem_addr_o = req_addr;

    assign instruction_o = instr_valid_o ? buf_mem[head].instr : NOP;
    assign pc_o          = instr_valid_o ? buf_mem[head].pc    : fetch_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (redirect_i) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            fetch_pc <= redirect_target;
            // An unacked request must stay on the bus; its data is dropped in FLUSH.
            if (state != HOLD && !imem_ack_i) begin
                state <= FLUSH;
            end else begin
                state    <= FETCH;
                req_addr <= redirect_target;
            end
        end else begin
            count <= count_after;
            if (push) tail <= ptr_inc(tail);
            if (pop)  head <= ptr_inc(head);
            case (state)
                FETCH: begin
                    if (imem_ack_i) begin
                        fetch_pc <= next_pc;
                        req_addr <= next_pc;
                        state    <= (count_after < CNT_W'(DEPTH)) ? FETCH : HOLD;
                    end
                end
                HOLD: begin
                    if (pop) state <= FETCH;
                end
                FLUSH: begin
                    if (imem_ack_i) begin
                        req_addr <= fetch_pc;
                        state    <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    // NOTE: buffer storage is not reset; every read is masked by instr_valid_o,
    // which derives from the reset count, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) buf_mem[tail] <= '{instr: imem_data_i, pc: req_addr};
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; memory returns a fixed function of the address.
// Expected tables follow FETCH_PREFETCH_EN so the same bench covers both buffer depths.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 32
`endif

module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_PREFETCH_EN
    localparam logic [5:0]  A_VALID = 6'b111111;
    localparam logic [31:0] A_PC [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    localparam logic [31:0] B6_VALID = 32'd1;
    localparam logic [31:0] B6_PC    = 32'h4;
    localparam logic [31:0] B6_ADDR  = 32'h8;
    localparam logic [31:0] B7_PC    = 32'h8;
    localparam int          D_LEAD   = 2;
`else
    localparam logic [5:0]  A_VALID = 6'b010101;
    localparam logic [31:0] A_PC [6] = '{32'h0, 32'h4, 32'h4, 32'h8, 32'h8, 32'hC};
    localparam logic [31:0] B6_VALID = 32'd0;
    localparam logic [31:0] B6_PC    = 32'h4;
    localparam logic [31:0] B6_ADDR  = 32'h4;
    localparam logic [31:0] B7_PC    = 32'h4;
    localparam int          D_LEAD   = 4;
`endif

    logic        clk;
    logic        rst;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic        instr_valid_o;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;

    logic ack_en;
    logic ack_force;
    int   vectors;
    int   miscompares;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    assign imem_ack_i  = ack_force | (ack_en & imem_req_o);
    assign imem_data_i = word(imem_addr_o);

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_data_i  (imem_data_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .stall_i      (stall_i),
        .instr_valid_o(instr_valid_o),
        .instruction_o(instruction_o),
        .pc_o         (pc_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enter_reset();
        rst = 1'b1;
        tick();
        tick();
    endtask

    task automatic release_reset();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        ack_en = 1'b0;
        ack_force = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 32'h0;
        stall_i = 1'b0;
        #2;
        check("rst_req",   32'(imem_req_o),    32'd0);
        check("rst_addr",  imem_addr_o,        32'h0);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_instr", instruction_o,      NOP);
        check("rst_pc",    pc_o,               32'h0);
        tick();
        tick();

        // Streaming with ack every cycle and no stall
        ack_en = 1'b1;
        release_reset();
        check("rel_req",  32'(imem_req_o), 32'd1);
        check("rel_addr", imem_addr_o,     32'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("a_valid", 32'(instr_valid_o), 32'(A_VALID[i]));
            check("a_pc",    pc_o,               A_PC[i]);
            check("a_instr", instruction_o,      A_VALID[i] ? word(A_PC[i]) : NOP);
        end

        // Stall for 5 cycles, then release
        enter_reset();
        stall_i = 1'b1;
        release_reset();
        tick();
        check("b_first_valid", 32'(instr_valid_o), 32'd1);
        check("b_first_pc",    pc_o,               32'h0);
        repeat (4) tick();
        check("b_hold_req",   32'(imem_req_o),    32'd0);
        check("b_hold_valid", 32'(instr_valid_o), 32'd1);
        check("b_hold_pc",    pc_o,               32'h0);
        check("b_hold_instr", instruction_o,      word(32'h0));
        stall_i = 1'b0;
        tick();
        check("b_rel_valid", 32'(instr_valid_o), B6_VALID);
        check("b_rel_pc",    pc_o,               B6_PC);
        check("b_rel_req",   32'(imem_req_o),    32'd1);
        check("b_rel_addr",  imem_addr_o,        B6_ADDR);
        tick();
        check("b_next_valid", 32'(instr_valid_o), 32'd1);
        check("b_next_pc",    pc_o,               B7_PC);

        // Redirect to 0x100 with the outstanding ack delayed 3 cycles
        enter_reset();
        ack_en = 1'b0;
        release_reset();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h100;
        tick();
        redirect_i = 1'b0;
        check("c_flush_addr",  imem_addr_o,        32'h0);
        check("c_flush_req",   32'(imem_req_o),    32'd1);
        check("c_flush_valid", 32'(instr_valid_o), 32'd0);
        check("c_flush_pc",    pc_o,               32'h100);
        tick();
        tick();
        check("c_held_addr", imem_addr_o, 32'h0);
        ack_en = 1'b1;
        tick();
        check("c_drop_valid", 32'(instr_valid_o), 32'd0);
        check("c_new_addr",   imem_addr_o,        32'h100);
        tick();
        check("c_valid", 32'(instr_valid_o), 32'd1);
        check("c_pc",    pc_o,               32'h100);
        check("c_instr", instruction_o,      word(32'h100));

        // Redirect to 0x203 coincident with the ack of 0x8
        enter_reset();
        ack_en = 1'b1;
        release_reset();
        repeat (D_LEAD) tick();
        check("d_pre_addr", imem_addr_o,     32'h8);
        check("d_pre_req",  32'(imem_req_o), 32'd1);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h203;
        tick();
        redirect_i = 1'b0;
        check("d_valid", 32'(instr_valid_o), 32'd0);
        check("d_addr",  imem_addr_o,        32'h200);
        check("d_req",   32'(imem_req_o),    32'd1);
        tick();
        check("d_new_valid", 32'(instr_valid_o), 32'd1);
        check("d_new_pc",    pc_o,               32'h200);
        check("d_new_instr", instruction_o,      word(32'h200));

        // Redirect to the top word; the following fetch wraps to 0
        enter_reset();
        ack_en = 1'b0;
        release_reset();
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_i = 1'b0;
        ack_en = 1'b1;
        check("e_flush_addr", imem_addr_o, 32'h0);
        tick();
        check("e_top_addr",  imem_addr_o,        32'hFFFF_FFFC);
        check("e_top_valid", 32'(instr_valid_o), 32'd0);
        tick();
        check("e_wrap_addr", imem_addr_o,        32'h0);
        check("e_top_pc",    pc_o,               32'hFFFF_FFFC);
        check("e_valid",     32'(instr_valid_o), 32'd1);

        // Reset asserted mid-cycle with the buffer full
        enter_reset();
        ack_en = 1'b1;
        stall_i = 1'b1;
        release_reset();
        tick();
        tick();
        check("f_full_valid", 32'(instr_valid_o), 32'd1);
        check("f_full_pc",    pc_o,               32'h0);
        #3;
        rst = 1'b1;
        ack_force = 1'b1;
        #1;
        check("f_rst_valid", 32'(instr_valid_o), 32'd0);
        check("f_rst_instr", instruction_o,      NOP);
        check("f_rst_pc",    pc_o,               32'h0);
        check("f_rst_req",   32'(imem_req_o),    32'd0);
        check("f_rst_addr",  imem_addr_o,        32'h0);
        tick();
        check("f_ack_ign_valid", 32'(instr_valid_o), 32'd0);
        check("f_ack_ign_addr",  imem_addr_o,        32'h0);
        ack_force = 1'b0;
        stall_i = 1'b0;
        release_reset();
        check("f_rel_req",  32'(imem_req_o), 32'd1);
        check("f_rel_addr", imem_addr_o,     32'h0);
        tick();
        check("f_rel_valid", 32'(instr_valid_o), 32'd1);
        check("f_rel_pc",    pc_o,               32'h0);
        check("f_rel_instr", instruction_o,      word(32'h0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
